// File: rtl/shop_pkg.sv
// Shared definitions for the shop calculator datapath: sequencer states and default widths.
package shop_pkg;

  localparam int W_IN_DEF    = 4;
  localparam int TIMES_W_DEF = 8;
  localparam int SUM_W_DEF   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MULT  = 2'd1,
    ST_ACCUM = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mul_shift_add.sv
// Multi-cycle shift-add multiplier: one partial product per cycle, W cycles after start.
module mul_shift_add #(
  parameter int W = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] prod_o,
  output logic           last_o
);

  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [2*W-1:0]   acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  logic [2*W-1:0]   partial;

  assign partial = {{W{1'b0}}, b_q} << cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start_i) begin
      a_q   <= a_i;
      b_q   <= b_i;
      acc_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      if (a_q[cnt_q]) acc_q <= acc_q + partial;
      cnt_q <= cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(W-1)) run_q <= 1'b0;
    end
  end

  assign prod_o = acc_q;
  // High during the final iteration cycle; the sequencer moves on at that edge.
  assign last_o = run_q && (cnt_q == CNT_W'(W-1));

endmodule

// File: rtl/checkout_ctrl.sv
// Scale/price sequencer: multiplies weight*per, accumulates a saturating sum and count, drives status flags.
//   state | meaning
//   IDLE  | waiting for cal; operands checked for zero here
//   MULT  | shift-add multiplier iterating
//   ACCUM | commit price, saturating sum and times
//   DONE  | done pulse visible; back to IDLE next
module checkout_ctrl
  import shop_pkg::*;
#(
  parameter int W_IN    = W_IN_DEF,
  parameter int TIMES_W = TIMES_W_DEF,
  parameter int SUM_W   = SUM_W_DEF
) (
  input  logic              clk100mhz,
  input  logic              reset,
  input  logic              cal,
  input  logic              clr,
  input  logic [W_IN-1:0]   weight,
  input  logic [W_IN-1:0]   per,
  output logic [2*W_IN-1:0] price,
  output logic [TIMES_W-1:0] times,
  output logic [SUM_W-1:0]  sum,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ovf,
  output logic              state_cal,
  output logic              state_reset
);

  localparam int SUM_X = SUM_W + 1;

  state_t             state_q;
  logic [2*W_IN-1:0]  price_q;
  logic [TIMES_W-1:0] times_q;
  logic [SUM_W-1:0]   sum_q;
  logic               busy_q, done_q, err_q, ovf_q, state_cal_q, state_reset_q;

  logic               ops_ok;
  logic               start;
  logic [2*W_IN-1:0]  prod;
  logic               mul_last;
  logic [SUM_W:0]     sum_d;

  assign ops_ok = (weight != '0) && (per != '0);
  assign start  = (state_q == ST_IDLE) && cal && !clr && ops_ok;
  // Carry out of the widened adder signals saturation.
  assign sum_d  = {1'b0, sum_q} + SUM_X'(prod);

  mul_shift_add #(.W(W_IN)) u_mul (
    .clk_i   (clk100mhz),
    .rst_i   (reset || clr),
    .start_i (start),
    .a_i     (weight),
    .b_i     (per),
    .prod_o  (prod),
    .last_o  (mul_last)
  );

  always_ff @(posedge clk100mhz) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      price_q       <= '0;
      times_q       <= '0;
      sum_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      ovf_q         <= 1'b0;
      state_cal_q   <= 1'b0;
      state_reset_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (clr) begin
        state_q       <= ST_IDLE;
        price_q       <= '0;
        times_q       <= '0;
        sum_q         <= '0;
        busy_q        <= 1'b0;
        ovf_q         <= 1'b0;
        state_cal_q   <= 1'b0;
        state_reset_q <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (cal) begin
              if (ops_ok) begin
                state_q <= ST_MULT;
                busy_q  <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          ST_MULT: begin
            if (mul_last) state_q <= ST_ACCUM;
          end
          ST_ACCUM: begin
            price_q <= prod;
            if (sum_d[SUM_W]) begin
              sum_q <= '1;
              ovf_q <= 1'b1;
            end else begin
              sum_q <= sum_d[SUM_W-1:0];
            end
            if (times_q != '1) times_q <= times_q + TIMES_W'(1);
            state_q       <= ST_DONE;
            busy_q        <= 1'b0;
            done_q        <= 1'b1;
            state_cal_q   <= 1'b1;
            state_reset_q <= 1'b0;
          end
          ST_DONE: state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign price       = price_q;
  assign times       = times_q;
  assign sum         = sum_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign ovf         = ovf_q;
  assign state_cal   = state_cal_q;
  assign state_reset = state_reset_q;

endmodule

// File: tb/tb_checkout_ctrl.sv
// Bench for checkout_ctrl: directed scenarios plus random operands against an arithmetic model.
module tb_checkout_ctrl;

  logic        clk = 1'b0;
  logic        reset, cal, clr;
  logic [3:0]  weight, per;
  logic [7:0]  price;
  logic [7:0]  times;
  logic [15:0] sum;
  logic        busy, done, err, ovf, state_cal, state_reset;

  int tests = 0;
  int fails = 0;

  // model of committed outputs
  int  m_price, m_sum, m_times;
  bit  m_ovf, m_scal, m_sreset;

  checkout_ctrl dut (
    .clk100mhz   (clk),
    .reset       (reset),
    .cal         (cal),
    .clr         (clr),
    .weight      (weight),
    .per         (per),
    .price       (price),
    .times       (times),
    .sum         (sum),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .ovf         (ovf),
    .state_cal   (state_cal),
    .state_reset (state_reset)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_price = 0; m_sum = 0; m_times = 0;
    m_ovf = 0; m_scal = 0; m_sreset = 1;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".price"}, price, m_price);
    chk({tag, ".sum"}, sum, m_sum);
    chk({tag, ".times"}, times, m_times);
    chk({tag, ".ovf"}, ovf, m_ovf);
    chk({tag, ".state_cal"}, state_cal, m_scal);
    chk({tag, ".state_reset"}, state_reset, m_sreset);
  endtask

  // Issues cal in the current cycle N and follows it to N+7.
  task automatic run_cal(input string tag, input int w, input int p,
                         input bit detailed, input bit poke);
    weight = 4'(w); per = 4'(p); cal = 1'b1;
    tick();
    cal = 1'b0;
    weight = 4'($urandom_range(0, 15));
    per    = 4'($urandom_range(0, 15));
    if (w == 0 || p == 0) begin
      chk({tag, ".err"}, err, 1);
      chk({tag, ".busy"}, busy, 0);
      tick();
      chk({tag, ".err_end"}, err, 0);
      chk({tag, ".done"}, done, 0);
      chk({tag, ".busy2"}, busy, 0);
      chk_regs(tag);
      return;
    end
    for (int i = 1; i <= 5; i++) begin
      if (detailed) begin
        chk($sformatf("%s.busy@N+%0d", tag, i), busy, 1);
        chk($sformatf("%s.done@N+%0d", tag, i), done, 0);
        if (i == 1) chk({tag, ".err"}, err, 0);
      end
      if (poke && (i == 2 || i == 4)) cal = 1'b1;
      tick();
      cal = 1'b0;
    end
    m_price = w * p;
    if (m_sum + m_price > 65535) begin
      m_sum = 65535; m_ovf = 1;
    end else begin
      m_sum = m_sum + m_price;
    end
    if (m_times < 255) m_times++;
    m_scal = 1; m_sreset = 0;
    chk({tag, ".done@N+6"}, done, 1);
    chk({tag, ".busy@N+6"}, busy, 0);
    chk_regs(tag);
    tick();
    chk({tag, ".done@N+7"}, done, 0);
    chk({tag, ".busy@N+7"}, busy, 0);
  endtask

  task automatic do_clr(input string tag);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    model_clear();
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk_regs(tag);
  endtask

  initial begin
    reset = 1'b1; cal = 1'b0; clr = 1'b0; weight = '0; per = '0;
    model_clear();
    tick();
    tick();
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.err", err, 0);
    chk_regs("rst");
    reset = 1'b0;
    tick();

    // basic product and accumulation
    run_cal("t1", 5, 7, 1, 0);
    run_cal("t2", 15, 15, 1, 1);
    chk("t2.times_final", times, 2);
    chk("t2.sum_final", sum, 260);

    // rejected operands
    run_cal("t3a", 0, 9, 1, 0);
    run_cal("t3b", 6, 0, 1, 0);

    // saturation of times and sum
    do_clr("t4clr0");
    for (int k = 1; k <= 292; k++) begin
      run_cal($sformatf("t4.%0d", k), 15, 15, 0, 0);
      if (k == 291) chk("t4.ovf_before", ovf, 0);
    end
    chk("t4.times_sat", times, 255);
    chk("t4.sum_sat", sum, 65535);
    chk("t4.ovf", ovf, 1);
    do_clr("t4clr");

    // clr aborts in-flight calculation
    weight = 4'd3; per = 4'd4; cal = 1'b1;
    tick();
    cal = 1'b0;
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t5.busy@N+4", busy, 0);
    chk("t5.done@N+4", done, 0);
    chk_regs("t5");
    run_cal("t5new", 3, 4, 1, 0);

    // cal and clr together: clr wins
    weight = 4'd9; per = 4'd9; cal = 1'b1; clr = 1'b1;
    tick();
    cal = 1'b0; clr = 1'b0;
    model_clear();
    chk("t6a.busy", busy, 0);
    chk("t6a.err", err, 0);
    chk_regs("t6a");
    tick();
    chk("t6a.busy2", busy, 0);
    chk("t6a.done2", done, 0);

    // reset mid-calculation
    run_cal("t6pre", 7, 3, 0, 0);
    weight = 4'd2; per = 4'd11; cal = 1'b1;
    tick();
    cal = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_clear();
    chk("t6b.busy", busy, 0);
    chk("t6b.done", done, 0);
    chk("t6b.err", err, 0);
    chk_regs("t6b");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6b.nodone", done, 0);
    end

    // reset clears a pending err
    weight = 4'd0; per = 4'd5; cal = 1'b1; reset = 1'b1;
    tick();
    cal = 1'b0; reset = 1'b0;
    chk("t6c.err", err, 0);

    // random operands, including zeros
    for (int k = 0; k < 30; k++) begin
      run_cal($sformatf("rnd%0d", k), $urandom_range(0, 15), $urandom_range(0, 15),
              bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 9) == 0) do_clr($sformatf("rndclr%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
